etapa_mem_wb: RTL
=================

Name: etapa_mem_wb

Overview:
MEM/WB pipeline register plus write-back data selection for the five-stage pipeline. Consumes the forced register-write enable produced by the MEM-stage write-enable mux, together with the ALU result, raw memory word and destination register. Performs load lane extraction and sign extension, then registers everything for the WB stage and register file.

Parameters:
ANCHO_DATOS, 32, data path width (must be 32; lane logic is fixed to 4 bytes)
ANCHO_DIR_REG, 5, register-file address width

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold current WB contents
flush  input  1  insert bubble into WB
valido_in  input  1  MEM-stage instruction valid
esc_reg_in  input  1  register-write enable from MEM-stage write-enable mux
mem_a_reg_in  input  1  1 = write back memory data, 0 = ALU result
tipo_carga_in  input  2  00 LW, 01 LH, 10 LB, 11 LBU
dir_baja_in  input  2  address bits [1:0] of the access
dato_mem_in  input  ANCHO_DATOS  raw aligned memory word
resultado_alu_in  input  ANCHO_DATOS  ALU result
reg_destino_in  input  ANCHO_DIR_REG  destination register
valido_wb  output  1  WB instruction valid
esc_reg_wb  output  1  register-file write enable
reg_destino_wb  output  ANCHO_DIR_REG  register-file write address
dato_wb  output  ANCHO_DATOS  register-file write data
error_alineacion_wb  output  1  misaligned load flagged in WB

Behaviour:
- One-cycle latency: inputs sampled at rising clk appear on outputs after that edge.
- All outputs are registered; no combinational input-to-output path.
- Update priority: reset > flush > stall > normal capture.
- Reset: all outputs are 0.
- Flush: valido_wb, esc_reg_wb and error_alineacion_wb become 0.
  - reg_destino_wb and dato_wb become 0.
- Stall without flush: every output holds its value.
  - A stall does not re-evaluate misalignment.
- Normal capture:
  - valido_wb = valido_in.
  - reg_destino_wb = reg_destino_in.
  - esc_reg_wb = esc_reg_in AND valido_in AND NOT mis.
  - mis = mem_a_reg_in AND (LW with dir_baja!=00, or LH with dir_baja[0]=1).
  - error_alineacion_wb = mis AND valido_in.
- dato_wb is resultado_alu_in when mem_a_reg_in=0. Otherwise it is the extracted load data:
  - LW: dato_mem_in unchanged. On misalignment the word is still passed through, but the write is blocked.
  - LH: half selected by dir_baja[1] (0 → bits 15:0, 1 → bits 31:16), sign-extended to 32 bits. dir_baja[0] is ignored for the data path.
  - LB: byte selected by dir_baja (00 → 7:0 … 11 → 31:24, little-endian), sign-extended.
  - LBU: same byte selection, zero-extended.
- tipo_carga_in and dir_baja_in are don't-care when mem_a_reg_in=0. No error is raised in that case.
- Simultaneous stall and flush: flush wins.
- Reset asserted mid-stall: reset wins; outputs clear on that edge.

Optional Feature:
Macro WB_R0_GUARD_EN.
- Defined: esc_reg_wb is additionally forced to 0 whenever reg_destino_in==0 at capture. Writes to register 0 never leave this stage.
- Undefined: no such gating; the register file is responsible for ignoring register 0.
- All other outputs are identical in both builds.

Decomposition:
- Shared package pipeline_pkg holds:
  - load-type encodings as constants: CARGA_LW=2'b00, CARGA_LH=2'b01, CARGA_LB=2'b10, CARGA_LBU=2'b11.
  - ANCHO_DATOS and ANCHO_DIR_REG defaults.
- One natural sub-module: extractor_carga, the purely combinational lane select plus sign/zero extension, reusable by a future forwarding path. Inputs are tipo, dir_baja and word; outputs are data and misaligned.
- etapa_mem_wb instantiates it and owns all registers.

Test Plan:
- Reset: assert reset 2 cycles with random inputs → all outputs 0. Release; capture ALU op with resultado_alu_in=32'h0000_1234, reg 7, esc_reg_in=1 → next edge dato_wb=32'h0000_1234, reg_destino_wb=7, esc_reg_wb=1, valido_wb=1.
- Loads from dato_mem_in=32'h80FF_7F01:
  - LB dir 00 → 32'h0000_0001.
  - LB dir 10 → 32'hFFFF_FFFF.
  - LB dir 11 → 32'hFFFF_FF80.
  - LBU dir 11 → 32'h0000_0080.
  - LH dir 10 → 32'hFFFF_80FF.
  - LH dir 00 → 32'h0000_7F01.
  - LW dir 00 → 32'h80FF_7F01.
- Misalignment: LW dir 01 with esc_reg_in=1 → error_alineacion_wb=1, esc_reg_wb=0. LH dir 11 → same flags, with dato_wb drawn from the upper half.
- Stall/flush:
  - Capture value A, then stall 3 cycles with new inputs → outputs stay A.
  - Assert stall and flush together → valido_wb=0, esc_reg_wb=0, dato_wb=0.
  - Release both → next input captured.
- Invalid instruction: valido_in=0, esc_reg_in=1 → esc_reg_wb=0, valido_wb=0.
- WB_R0_GUARD_EN: reg_destino_in=0, esc_reg_in=1, valido_in=1 → esc_reg_wb=0 with macro defined, 1 without. Run the bench in both builds.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
//
// Definitions shared by the five-stage pipeline:
//   - default data-path and register-address widths
//   - load-type encodings carried from decode down to write-back
//
// Load-type encoding (tipo_carga):
//   CARGA_LW  2'b00  32-bit word
//   CARGA_LH  2'b01  16-bit half, sign-extended
//   CARGA_LB  2'b10  8-bit byte, sign-extended
//   CARGA_LBU 2'b11  8-bit byte, zero-extended
// ---------------------------------------------------------------------------
package pipeline_pkg;

    localparam int ANCHO_DATOS   = 32;
    localparam int ANCHO_DIR_REG = 5;

    localparam logic [1:0] CARGA_LW  = 2'b00;
    localparam logic [1:0] CARGA_LH  = 2'b01;
    localparam logic [1:0] CARGA_LB  = 2'b10;
    localparam logic [1:0] CARGA_LBU = 2'b11;

endpackage : pipeline_pkg

// File: rtl/extractor_carga.sv
// ---------------------------------------------------------------------------
// extractor_carga
//
// Purely combinational load lane selection plus sign/zero extension.
// Kept separate from the MEM/WB register so that a forwarding path can
// reuse exactly the same extraction logic.
//
// Ports:
//   tipo         in  [1:0]   load type (see pipeline_pkg CARGA_*)
//   dir_baja     in  [1:0]   address bits [1:0] of the access
//   palabra      in  [31:0]  raw aligned memory word
//   dato         out [31:0]  extracted, extended load data
//   desalineado  out         access not naturally aligned for its type
//
// Lanes are little-endian: dir_baja 00 selects bits 7:0, 11 selects 31:24.
// For halves only dir_baja[1] picks the lane; dir_baja[0] affects the
// misalignment flag but not the data.  A misaligned word is still passed
// through unchanged; the caller decides whether to block the write.
// ---------------------------------------------------------------------------
module extractor_carga
    import pipeline_pkg::*;
(
    input  logic [1:0]  tipo,
    input  logic [1:0]  dir_baja,
    input  logic [31:0] palabra,
    output logic [31:0] dato,
    output logic        desalineado
);

    logic [7:0]  byte_sel;
    logic [15:0] media_sel;

    // Byte lane select
    always_comb begin
        byte_sel = palabra[7:0];
        case (dir_baja)
            2'b00:   byte_sel = palabra[7:0];
            2'b01:   byte_sel = palabra[15:8];
            2'b10:   byte_sel = palabra[23:16];
            2'b11:   byte_sel = palabra[31:24];
            default: byte_sel = palabra[7:0];
        endcase
    end

    // Half lane select: only the upper address bit matters here
    always_comb begin
        media_sel = palabra[15:0];
        if (dir_baja[1]) begin
            media_sel = palabra[31:16];
        end
    end

    // Extension and misalignment detection
    always_comb begin
        dato        = palabra;
        desalineado = 1'b0;
        case (tipo)
            CARGA_LW: begin
                dato        = palabra;
                desalineado = (dir_baja != 2'b00);
            end
            CARGA_LH: begin
                dato        = {{16{media_sel[15]}}, media_sel};
                desalineado = dir_baja[0];
            end
            CARGA_LB: begin
                dato        = {{24{byte_sel[7]}}, byte_sel};
                desalineado = 1'b0;
            end
            CARGA_LBU: begin
                dato        = {24'h000000, byte_sel};
                desalineado = 1'b0;
            end
            default: begin
                dato        = palabra;
                desalineado = 1'b0;
            end
        endcase
    end

endmodule : extractor_carga

// File: rtl/etapa_mem_wb.sv
// ---------------------------------------------------------------------------
// etapa_mem_wb
//
// MEM/WB pipeline register with write-back data selection.  Load data is
// extracted and extended from the raw memory word (extractor_carga), then
// everything is registered for the WB stage and the register file.
// One cycle of latency; every output comes straight from a flop.
//
// Parameters:
//   ANCHO_DATOS    data path width, must be 32 (lane logic is 4 bytes)
//   ANCHO_DIR_REG  register-file address width
//
// Ports:
//   clk                  in   pipeline clock, rising edge
//   reset                in   synchronous, active-high reset
//   stall                in   hold current WB contents
//   flush                in   insert bubble into WB
//   valido_in            in   MEM-stage instruction valid
//   esc_reg_in           in   register-write enable from MEM write-enable mux
//   mem_a_reg_in         in   1 = write back memory data, 0 = ALU result
//   tipo_carga_in        in   [1:0] 00 LW, 01 LH, 10 LB, 11 LBU
//   dir_baja_in          in   [1:0] address bits [1:0] of the access
//   dato_mem_in          in   raw aligned memory word
//   resultado_alu_in     in   ALU result
//   reg_destino_in       in   destination register
//   valido_wb            out  WB instruction valid
//   esc_reg_wb           out  register-file write enable
//   reg_destino_wb       out  register-file write address
//   dato_wb              out  register-file write data
//   error_alineacion_wb  out  misaligned load flagged in WB
//
// Pipeline control: update priority is reset > flush > stall > capture.
// flush turns the WB slot into an all-zero bubble; stall holds every
// output (misalignment is not re-evaluated while held).
//
// Build option WB_R0_GUARD_EN: when defined, a write to register 0 is
// suppressed here (esc_reg_wb forced low).  When undefined the register
// file is expected to ignore register 0 itself.  No other output differs.
// ---------------------------------------------------------------------------
module etapa_mem_wb
    import pipeline_pkg::*;
#(
    parameter int ANCHO_DATOS   = pipeline_pkg::ANCHO_DATOS,
    parameter int ANCHO_DIR_REG = pipeline_pkg::ANCHO_DIR_REG
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     valido_in,
    input  logic                     esc_reg_in,
    input  logic                     mem_a_reg_in,
    input  logic [1:0]               tipo_carga_in,
    input  logic [1:0]               dir_baja_in,
    input  logic [ANCHO_DATOS-1:0]   dato_mem_in,
    input  logic [ANCHO_DATOS-1:0]   resultado_alu_in,
    input  logic [ANCHO_DIR_REG-1:0] reg_destino_in,
    output logic                     valido_wb,
    output logic                     esc_reg_wb,
    output logic [ANCHO_DIR_REG-1:0] reg_destino_wb,
    output logic [ANCHO_DATOS-1:0]   dato_wb,
    output logic                     error_alineacion_wb
);

    logic [ANCHO_DATOS-1:0] dato_carga;
    logic                   desalineado_carga;

    logic                   mis;
    logic                   bloqueo_r0;
    logic                   esc_captura;
    logic                   error_captura;
    logic [ANCHO_DATOS-1:0] dato_captura;

    extractor_carga u_extractor (
        .tipo        (tipo_carga_in),
        .dir_baja    (dir_baja_in),
        .palabra     (dato_mem_in),
        .dato        (dato_carga),
        .desalineado (desalineado_carga)
    );

    // Misalignment only matters for loads; ALU results never raise it.
    assign mis = mem_a_reg_in & desalineado_carga;

`ifdef WB_R0_GUARD_EN
    assign bloqueo_r0 = (reg_destino_in == '0);
`else
    assign bloqueo_r0 = 1'b0;
`endif

    assign esc_captura   = esc_reg_in & valido_in & ~mis & ~bloqueo_r0;
    assign error_captura = mis & valido_in;
    assign dato_captura  = mem_a_reg_in ? dato_carga : resultado_alu_in;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valido_wb           <= 1'b0;
            esc_reg_wb          <= 1'b0;
            reg_destino_wb      <= '0;
            dato_wb             <= '0;
            error_alineacion_wb <= 1'b0;
        end else if (!stall) begin
            valido_wb           <= valido_in;
            esc_reg_wb          <= esc_captura;
            reg_destino_wb      <= reg_destino_in;
            dato_wb             <= dato_captura;
            error_alineacion_wb <= error_captura;
        end
    end

endmodule : etapa_mem_wb
